// File: rtl/shift_sched_ctrl_pkg.sv
// Shared types and sizing for the barrel-shifter rotation scheduler.
// PORT_NUB follows PORT_NUB_TOTAL from the switch build.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif

package shift_sched_ctrl_pkg;

  localparam int PORT_NUB = `PORT_NUB_TOTAL;

  localparam int SEL_W = $clog2(PORT_NUB);
  // one shifter register stage per select bit
  localparam int LAT   = SEL_W;
  localparam int CNT_W = $clog2(LAT + 1);

`ifdef SHIFT_SCHED_CNT_EN
  localparam int FCNT_W = 16;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic sel_t sel_next(sel_t s);
    return s + sel_t'(1);
  endfunction

  function automatic logic sel_last(sel_t s);
    return s == sel_t'(PORT_NUB - 1);
  endfunction

endpackage

// File: rtl/shift_sched_ctrl_if.sv
// Command/status bundle between the scheduler and its user.
// frame_cnt is present only with SHIFT_SCHED_CNT_EN.
interface shift_sched_ctrl_if;
  import shift_sched_ctrl_pkg::*;

  logic start;
  logic stop;
  sel_t sel;
  logic in_valid;
  logic frame_start;
  logic out_valid;
  sel_t out_sel;
  logic busy;
  logic done;
`ifdef SHIFT_SCHED_CNT_EN
  logic [FCNT_W-1:0] frame_cnt;
`endif

  modport master (
    input  start, stop,
    output sel, in_valid, frame_start,
    output out_valid, out_sel, busy, done
`ifdef SHIFT_SCHED_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output start, stop,
    input  sel, in_valid, frame_start,
    input  out_valid, out_sel, busy, done
`ifdef SHIFT_SCHED_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/shift_sched_ctrl_delay.sv
// Width x depth shift register mirroring the shifter pipeline.
// Async reset clears every stage so nothing stale leaks out.
module sched_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      q_q[0] <= d_i;
      for (int i = 1; i < D; i++) begin
        q_q[i] <= q_q[i-1];
      end
    end
  end

  assign q_o = q_q[D-1];

endmodule

// File: rtl/shift_sched_ctrl.sv
// Round-robin rotate scheduler with frame-aligned start/stop and drain.
// Optional SHIFT_SCHED_CNT_EN adds a 16-bit frame counter.
module shift_sched_ctrl
  import shift_sched_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  shift_sched_ctrl_if.master bus
);

  state_e           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic in_valid;
  logic frame_start;
  logic dly_valid;
  sel_t dly_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        sel_d = sel_next(sel_q);
        if (bus.stop) pend_d = 1'b1;
        // leave only on the last slot so frames stay whole
        if (sel_last(sel_q) && (pend_q || bus.stop)) begin
          state_d = DRAIN;
          pend_d  = 1'b0;
          cnt_d   = CNT_W'(LAT);
        end
      end
      DRAIN: begin
        sel_d = '0;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        pend_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_valid    = (state_q == RUN);
  assign frame_start = in_valid && (sel_q == '0);

  sched_delay_line #(.W(1), .D(LAT)) u_dly_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (in_valid),
    .q_o   (dly_valid)
  );

  sched_delay_line #(.W(SEL_W), .D(LAT)) u_dly_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sel_q),
    .q_o   (dly_sel)
  );

  assign bus.sel         = sel_q;
  assign bus.in_valid    = in_valid;
  assign bus.frame_start = frame_start;
  assign bus.out_valid   = dly_valid;
  assign bus.out_sel     = dly_sel;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;

`ifdef SHIFT_SCHED_CNT_EN
  logic [FCNT_W-1:0] fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else if (frame_start) begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign bus.frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_shift_sched_ctrl.sv
// Scoreboard bench for shift_sched_ctrl (PORT_NUB=8, LAT=3).
// Frame counter checked when SHIFT_SCHED_CNT_EN is defined.
module tb_shift_sched_ctrl;
  import shift_sched_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  int   exp_frames = 0;
  int   exp_q[$];

  shift_sched_ctrl_if bus ();

  shift_sched_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, int act, int req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, act, req, $time);
    end
  endfunction

  // out_sel must follow the launched sel sequence in order
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL out_sel_spurious: got out_valid with out_sel=%0d, expected none at %0t",
                 bus.out_sel, $time);
      end else begin
        chk("out_sel", int'(bus.out_sel), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frames();
`ifdef SHIFT_SCHED_CNT_EN
    chk("frame_cnt", int'(bus.frame_cnt), exp_frames % 65536);
`endif
  endtask

  // Start from IDLE, run nrun RUN cycles (stop issued at stop_c),
  // optional start at start_c, stop in IDLE after done.
  task automatic run_seq(input int nrun, input int stop_c,
                         input int start_c, input logic both);
    logic run;
    for (int k = 0; k < nrun; k++) exp_q.push_back(k % 8);
    bus.start = 1'b1;
    bus.stop  = both;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int c = 1; c <= nrun + 6; c++) begin
      run = (c <= nrun);
      chk("sel", int'(bus.sel), run ? (c - 1) % 8 : 0);
      chk("in_valid", int'(bus.in_valid), int'(run));
      chk("frame_start", int'(bus.frame_start),
          int'(run && ((c - 1) % 8 == 0)));
      chk("out_valid", int'(bus.out_valid), int'(c >= 4 && c <= nrun + 3));
      chk("busy", int'(bus.busy), int'(c <= nrun + 3));
      chk("done", int'(bus.done), int'(c == nrun + 4));
      bus.stop  = (c == stop_c) || (c == nrun + 5);
      bus.start = (c == start_c);
      tick();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("sb_empty", exp_q.size(), 0);
    exp_frames += nrun / 8;
    chk_frames();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_in_valid", int'(bus.in_valid), 0);
    chk("rst_frame_start", int'(bus.frame_start), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sel", int'(bus.out_sel), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk_frames();
    tick();
    tick();

    // two frames, stop on sel=3 of the second
    run_seq(16, 12, 0, 1'b0);
    // start+stop in IDLE starts; stop on sel=7 of frame 2
    run_seq(16, 16, 0, 1'b1);
    // start during DRAIN is ignored
    run_seq(8, 5, 10, 1'b0);
    // start+stop in RUN acts as stop
    run_seq(8, 3, 3, 1'b0);

    // reset mid-RUN at sel=5
    exp_q.push_back(0);
    exp_q.push_back(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_sel", int'(bus.sel), 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", int'(bus.sel), 0);
    chk("mid_rst_in_valid", int'(bus.in_valid), 0);
    chk("mid_rst_frame_start", int'(bus.frame_start), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_sel", int'(bus.out_sel), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_frames = 0;
    for (int c = 0; c < 8; c++) begin
      chk("post_rst_out_valid", int'(bus.out_valid), 0);
      chk("post_rst_busy", int'(bus.busy), 0);
      tick();
    end
    chk("post_rst_sb_empty", exp_q.size(), 0);
    chk_frames();

    // 300 frames back to back, stop on sel=3 of the last
    run_seq(2400, 2396, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/shift_sched_ctrl.md
Name: shift_sched_ctrl

Overview:
- Time-division scheduler for the pipelined port-rotation barrel shifter in the shared-cache switch.
- Each cycle it drives the rotate amount (0..PORT_NUB-1, round-robin) and an input-slot strobe.
- It tracks the shifter's fixed pipeline latency so it can present out_valid/out_sel aligned with shifted data.
- Owns start/stop sequencing: rotation is always frame-aligned, and the pipeline drains before going idle.

Parameters:
- PORT_NUB, 8, number of switch ports; power of two, ≥2; equals `PORT_NUB_TOTAL.
- SEL_W, $clog2(PORT_NUB), rotate-amount width.
- LAT, SEL_W, barrel shifter pipeline depth in cycles (one register stage per select bit).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse: request rotation start
- stop  in  1  pulse: request stop at end of current frame
- sel  out  SEL_W  rotate amount to barrel shifter select
- in_valid  out  1  port_in slot is live this cycle (upstream may present data)
- frame_start  out  1  high on the cycle sel==0 while in_valid
- out_valid  out  1  port_out carries data launched LAT cycles earlier
- out_sel  out  SEL_W  rotate amount that produced current port_out
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset: state=IDLE, sel=0, out_sel=0, all 1-bit outputs 0, stop_pend=0, drain counter=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - sel held at 0; in_valid=0.
  - start=1 -> RUN next cycle. First RUN cycle: sel=0, in_valid=1, frame_start=1.
- RUN:
  - in_valid=1 every cycle; sel increments by 1 mod PORT_NUB each cycle (wraps PORT_NUB-1 -> 0).
  - frame_start=1 exactly when sel==0.
  - stop sets stop_pend. On the cycle sel==PORT_NUB-1 with stop_pend (or stop itself) high: go to DRAIN, clear stop_pend, load drain counter with LAT.
  - A stop arriving on the sel==PORT_NUB-1 cycle takes effect that cycle; a full frame always completes.
- DRAIN:
  - in_valid=0; sel returns to 0.
  - Counter decrements each cycle. When it reaches 1, next state is IDLE and done=1 on the IDLE-entry cycle.
- Validity pipeline:
  - out_valid is in_valid through a LAT-deep register chain; out_sel is sel through an identical chain.
  - Both are registered outputs, independent of state. This keeps the last frame's out_valid high through DRAIN.
- Command priority:
  - start in RUN or DRAIN: ignored.
  - stop in IDLE or DRAIN: ignored.
  - start and stop together in IDLE: start wins, stop is dropped.
  - start and stop together in RUN: treated as stop.
- Frame shape: RUN length is always a multiple of PORT_NUB cycles; a frame is never truncated.
- Reset mid-operation: asynchronous return to the reset values above. The delay chains clear, so no spurious out_valid appears after reset release.
- No backpressure: the shifter has no enable, so the scheduler never stalls.

Optional Feature:
- Macro: SHIFT_SCHED_CNT_EN.
- Defined:
  - Adds output frame_cnt (16 bits).
  - Resets to 0, increments on each frame_start, wraps 0xFFFF -> 0.
  - Holds value in IDLE/DRAIN; not cleared by start.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Shared package/defines (alongside defind.vh): state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2; PORT_NUB/SEL_W derivation from `PORT_NUB_TOTAL.
- One sub-module, sched_delay_line: parameterised width×depth shift register with async reset. Instantiated twice, for in_valid (1 bit) and sel (SEL_W bits), with depth LAT.

Test Plan:
- PORT_NUB=8. Reset, start at cycle 0 -> sel 0,1,..,7,0 from cycle 1; frame_start at cycles 1 and 9; out_valid first high at cycle 4 with out_sel=0.
- stop at sel=3 -> RUN continues to sel=7. DRAIN for 3 cycles with in_valid=0 while out_valid stays high; done pulses once; out_valid low after the last out_sel=7.
- stop on the sel=7 cycle -> DRAIN entered next cycle, no extra frame. start and stop together in IDLE -> RUN starts.
- Assert rst_n low mid-RUN at sel=5 -> all outputs 0 immediately. After release, no out_valid until a new start plus LAT cycles.
- Wraparound: 300 frames back-to-back -> out_sel sequence equals sel delayed exactly 3 cycles. With SHIFT_SCHED_CNT_EN, frame_cnt=300.
- start during DRAIN ignored (no RUN re-entry, done still pulses). stop in IDLE ignored (busy stays 0).
